// File: rtl/clock_mode_controller.sv
// Mode/edit FSM for the alarm clock: turns button pulses into time-counter controls,
// keeps the BCD alarm registers, and raises alarm_ring on the first cycle time meets the alarm.
module clock_mode_controller #(
  parameter int RING_TICKS  = 600,
  parameter int ALARM_H_RST = 0,
  parameter int ALARM_M_RST = 0
) (
  input  logic       clock_out,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       center,
  input  logic [1:0] th1,
  input  logic [3:0] th2,
  input  logic [2:0] tm1,
  input  logic [3:0] tm2,
  output logic       time_en,
  output logic       en_th,
  output logic       en_tm,
  output logic       updown,
  output logic [1:0] ah1,
  output logic [3:0] ah2,
  output logic [2:0] am1,
  output logic [3:0] am2,
  output logic [2:0] mode,
  output logic       disp_sel,
  output logic [3:0] blink,
  output logic       alarm_ring
);

  localparam int CW = $clog2(RING_TICKS + 1);

  typedef enum logic [2:0] {
    NORM = 3'b000,
    TH   = 3'b001,
    TM   = 3'b010,
    AH   = 3'b011,
    AM   = 3'b100
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   ring_cnt;
  logic            match;
  logic            match_d;
  logic            nav_r;
  logic            nav_l;
  logic            adj;

  assign mode  = state;
  assign nav_r = right & ~left & ~center;
  assign nav_l = left & ~right & ~center;
  assign adj   = (up ^ down) & ~center & ~(left ^ right);
  assign match = (th1 == ah1) && (th2 == ah2) && (tm1 == am1) && (tm2 == am2);

  function automatic logic [5:0] hour_step(input logic [1:0] t, input logic [3:0] u, input logic inc);
    logic [5:0] r;
    if (inc) begin
      if (t == 2'd2 && u == 4'd3) r = 6'd0;
      else if (u == 4'd9)         r = {t + 2'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
      else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] min_step(input logic [2:0] t, input logic [3:0] u, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (t == 3'd5 && u == 4'd9) r = 7'd0;
      else if (u == 4'd9)         r = {t + 3'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 3'd0 && u == 4'd0) r = {3'd5, 4'd9};
      else if (u == 4'd0)         r = {t - 3'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      NORM: if (center && !alarm_ring) state_nxt = TH;
      TH:   if (center) state_nxt = NORM; else if (nav_r) state_nxt = TM; else if (nav_l) state_nxt = AM;
      TM:   if (center) state_nxt = NORM; else if (nav_r) state_nxt = AH; else if (nav_l) state_nxt = TH;
      AH:   if (center) state_nxt = NORM; else if (nav_r) state_nxt = AM; else if (nav_l) state_nxt = TM;
      AM:   if (center) state_nxt = NORM; else if (nav_r) state_nxt = TH; else if (nav_l) state_nxt = AH;
      default: state_nxt = NORM;
    endcase
  end

  always_ff @(posedge clock_out or posedge rst) begin
    if (rst) begin
      state      <= NORM;
      time_en    <= 1'b1;
      en_th      <= 1'b0;
      en_tm      <= 1'b0;
      updown     <= 1'b0;
      disp_sel   <= 1'b0;
      blink      <= 4'b0000;
      ah1        <= 2'(ALARM_H_RST / 10);
      ah2        <= 4'(ALARM_H_RST % 10);
      am1        <= 3'(ALARM_M_RST / 10);
      am2        <= 4'(ALARM_M_RST % 10);
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
      match_d    <= 1'b1;
    end else begin
      state    <= state_nxt;
      time_en  <= (state_nxt == NORM);
      disp_sel <= (state_nxt == AH) || (state_nxt == AM);
      case (state_nxt)
        TH, AH:  blink <= 4'b1100;
        TM, AM:  blink <= 4'b0011;
        default: blink <= 4'b0000;
      endcase
      en_th  <= (state == TH) && adj;
      en_tm  <= (state == TM) && adj;
      updown <= ((state == TH) || (state == TM)) && adj && up;
      if (state == AH && adj) {ah1, ah2} <= hour_step(ah1, ah2, up);
      if (state == AM && adj) {am1, am2} <= min_step(am1, am2, up);
      match_d <= match;
      // Any center in NORM either silences or leaves NORM, so it always ends a ring.
      if (state != NORM || center) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else if (match && !match_d) begin
        alarm_ring <= 1'b1;
        ring_cnt   <= CW'(RING_TICKS - 1);
      end else if (alarm_ring) begin
        if (ring_cnt == '0) alarm_ring <= 1'b0;
        else                ring_cnt   <= ring_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: navigation, adjust pulses, BCD alarm wrap and ring timing.
module tb_clock_mode_controller;

  localparam int RT = 600;

  logic       clock_out = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic [1:0] th1 = 2'd1;
  logic [3:0] th2 = 4'd2;
  logic [2:0] tm1 = 3'd0;
  logic [3:0] tm2 = 4'd0;
  logic       time_en, en_th, en_tm, updown, disp_sel, alarm_ring;
  logic [1:0] ah1;
  logic [3:0] ah2;
  logic [2:0] am1;
  logic [3:0] am2;
  logic [2:0] mode;
  logic [3:0] blink;
  logic [25:0] outv;
  logic [25:0] rst_exp;

  int total = 0;
  int bad = 0;

  clock_mode_controller #(.RING_TICKS(RT), .ALARM_H_RST(0), .ALARM_M_RST(0)) dut (
    .clock_out(clock_out), .rst(rst),
    .up(up), .down(down), .left(left), .right(right), .center(center),
    .th1(th1), .th2(th2), .tm1(tm1), .tm2(tm2),
    .time_en(time_en), .en_th(en_th), .en_tm(en_tm), .updown(updown),
    .ah1(ah1), .ah2(ah2), .am1(am1), .am2(am2),
    .mode(mode), .disp_sel(disp_sel), .blink(blink), .alarm_ring(alarm_ring)
  );

  always #5 clock_out = ~clock_out;

  assign outv = {mode, time_en, en_th, en_tm, updown, disp_sel, blink, alarm_ring, ah1, ah2, am1, am2};
  assign rst_exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 3'd0, 4'd0};

  task automatic tick();
    @(posedge clock_out);
    #1;
  endtask

  // b = {center,left,right,up,down}, held for exactly one sampling edge
  task automatic press(input logic [4:0] b);
    {center, left, right, up, down} = b;
    tick();
    {center, left, right, up, down} = 5'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (outv !== rst_exp) begin bad++; $display("FAIL reset_outputs got=%h want=%h", outv, rst_exp); end
    rst = 1'b0;
    tick();
    total++;
    if (outv !== rst_exp) begin bad++; $display("FAIL idle_after_reset got=%h want=%h", outv, rst_exp); end
  endtask

  task automatic test_time_edit();
    int pulses;
    pulses = 0;
    press(5'b10000);
    total++;
    if (mode !== 3'd1 || time_en !== 1'b0 || blink !== 4'b1100 || disp_sel !== 1'b0) begin
      bad++; $display("FAIL enter_th mode=%0d time_en=%b blink=%b disp_sel=%b want 1 0 1100 0", mode, time_en, blink, disp_sel);
    end
    for (int i = 0; i < 3; i++) begin
      press(5'b00010);
      if (en_th === 1'b1 && updown === 1'b1 && en_tm === 1'b0) pulses++;
      tick();
      total++;
      if (en_th !== 1'b0) begin bad++; $display("FAIL en_th_single_cycle i=%0d got=%b want=0", i, en_th); end
    end
    total++;
    if (pulses != 3) begin bad++; $display("FAIL en_th_pulse_count got=%0d want=3", pulses); end
    press(5'b10000);
    total++;
    if (mode !== 3'd0 || time_en !== 1'b1 || blink !== 4'b0000) begin
      bad++; $display("FAIL back_to_norm mode=%0d time_en=%b blink=%b want 0 1 0000", mode, time_en, blink);
    end
  endtask

  task automatic test_alarm_hour();
    press(5'b10000);
    press(5'b00100);
    press(5'b00100);
    total++;
    if (mode !== 3'd3 || disp_sel !== 1'b1 || blink !== 4'b1100) begin
      bad++; $display("FAIL enter_ah mode=%0d disp_sel=%b blink=%b want 3 1 1100", mode, disp_sel, blink);
    end
    press(5'b00001);
    total++;
    if ({ah1, ah2} !== {2'd2, 4'd3}) begin bad++; $display("FAIL ah_00_down got=%0d%0d want=23", ah1, ah2); end
    press(5'b00010);
    total++;
    if ({ah1, ah2} !== {2'd0, 4'd0}) begin bad++; $display("FAIL ah_23_up got=%0d%0d want=00", ah1, ah2); end
    for (int i = 0; i < 10; i++) press(5'b00010);
    total++;
    if ({ah1, ah2} !== {2'd1, 4'd0}) begin bad++; $display("FAIL ah_bcd_carry got=%0d%0d want=10", ah1, ah2); end
    press(5'b00001);
    total++;
    if ({ah1, ah2} !== {2'd0, 4'd9}) begin bad++; $display("FAIL ah_bcd_borrow got=%0d%0d want=09", ah1, ah2); end
  endtask

  task automatic test_alarm_min();
    press(5'b00100);
    total++;
    if (mode !== 3'd4 || blink !== 4'b0011 || disp_sel !== 1'b1) begin
      bad++; $display("FAIL enter_am mode=%0d blink=%b disp_sel=%b want 4 0011 1", mode, blink, disp_sel);
    end
    press(5'b00001);
    total++;
    if ({am1, am2, ah1, ah2} !== {3'd5, 4'd9, 2'd0, 4'd9}) begin
      bad++; $display("FAIL am_00_down got=%0d%0d:%0d%0d want=09:59", ah1, ah2, am1, am2);
    end
    press(5'b00010);
    total++;
    if ({am1, am2, ah1, ah2} !== {3'd0, 4'd0, 2'd0, 4'd9}) begin
      bad++; $display("FAIL am_59_up got=%0d%0d:%0d%0d want=09:00", ah1, ah2, am1, am2);
    end
    press(5'b01000);
    total++;
    if (mode !== 3'd3) begin bad++; $display("FAIL left_to_ah got=%0d want=3", mode); end
    press(5'b01000);
    total++;
    if (mode !== 3'd2 || disp_sel !== 1'b0 || blink !== 4'b0011) begin
      bad++; $display("FAIL left_to_tm mode=%0d disp_sel=%b blink=%b want 2 0 0011", mode, disp_sel, blink);
    end
    press(5'b01100);
    total++;
    if (mode !== 3'd2) begin bad++; $display("FAIL left_right_ignored got=%0d want=2", mode); end
    press(5'b00001);
    total++;
    if (en_tm !== 1'b1 || updown !== 1'b0 || en_th !== 1'b0) begin
      bad++; $display("FAIL tm_down_pulse en_tm=%b updown=%b en_th=%b want 1 0 0", en_tm, updown, en_th);
    end
    press(5'b01000);
    total++;
    if (mode !== 3'd1) begin bad++; $display("FAIL left_to_th got=%0d want=1", mode); end
  endtask

  task automatic test_center_priority();
    press(5'b10010);
    total++;
    if (mode !== 3'd0 || en_th !== 1'b0 || time_en !== 1'b1) begin
      bad++; $display("FAIL center_over_up mode=%0d en_th=%b time_en=%b want 0 0 1", mode, en_th, time_en);
    end
  endtask

  task automatic test_alarm_ring();
    press(5'b10000);
    press(5'b00100);
    press(5'b00100);
    press(5'b00001);
    press(5'b00001);
    press(5'b00100);
    for (int i = 0; i < 30; i++) press(5'b00010);
    total++;
    if ({ah1, ah2, am1, am2} !== {2'd0, 4'd7, 3'd3, 4'd0}) begin
      bad++; $display("FAIL alarm_set got=%0d%0d:%0d%0d want=07:30", ah1, ah2, am1, am2);
    end
    press(5'b10000);
    {th1, th2, tm1, tm2} = {2'd0, 4'd7, 3'd2, 4'd9};
    tick();
    tick();
    total++;
    if (alarm_ring !== 1'b0 || mode !== 3'd0) begin bad++; $display("FAIL no_ring_0729 ring=%b mode=%0d want 0 0", alarm_ring, mode); end
    {tm1, tm2} = {3'd3, 4'd0};
    tick();
    total++;
    if (alarm_ring !== 1'b1) begin bad++; $display("FAIL ring_start got=%b want=1", alarm_ring); end
    repeat (RT - 1) tick();
    total++;
    if (alarm_ring !== 1'b1) begin bad++; $display("FAIL ring_hold_last got=%b want=1", alarm_ring); end
    tick();
    total++;
    if (alarm_ring !== 1'b0) begin bad++; $display("FAIL ring_timeout got=%b want=0", alarm_ring); end
    repeat (20) tick();
    total++;
    if (alarm_ring !== 1'b0) begin bad++; $display("FAIL no_retrigger got=%b want=0", alarm_ring); end
  endtask

  task automatic test_ring_silence();
    tm2 = 4'd1;
    tick();
    tick();
    tm2 = 4'd0;
    tick();
    repeat (5) tick();
    total++;
    if (alarm_ring !== 1'b1) begin bad++; $display("FAIL ring_restart got=%b want=1", alarm_ring); end
    press(5'b10000);
    total++;
    if (alarm_ring !== 1'b0 || mode !== 3'd0) begin
      bad++; $display("FAIL center_silence ring=%b mode=%0d want 0 0", alarm_ring, mode);
    end
    repeat (10) tick();
    total++;
    if (alarm_ring !== 1'b0) begin bad++; $display("FAIL silence_holds got=%b want=0", alarm_ring); end
  endtask

  task automatic test_ring_reset();
    tm2 = 4'd1;
    tick();
    tm2 = 4'd0;
    tick();
    total++;
    if (alarm_ring !== 1'b1) begin bad++; $display("FAIL ring_before_reset got=%b want=1", alarm_ring); end
    #2;
    {th1, th2, tm1, tm2} = '0;
    rst = 1'b1;
    #1;
    total++;
    if (outv !== rst_exp) begin bad++; $display("FAIL async_reset got=%h want=%h", outv, rst_exp); end
    tick();
    rst = 1'b0;
    repeat (5) tick();
    total++;
    if (alarm_ring !== 1'b0 || mode !== 3'd0) begin
      bad++; $display("FAIL no_ring_at_release ring=%b mode=%0d want 0 0", alarm_ring, mode);
    end
  endtask

  initial begin
    test_reset();
    test_time_edit();
    test_alarm_hour();
    test_alarm_min();
    test_center_priority();
    test_alarm_ring();
    test_ring_silence();
    test_ring_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
